// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg
// Shared definitions for the mtm_Alu datapath (deserializer, ALU core,
// serializer): opcodes, frame type codes, error flag bit positions,
// deserializer state encoding and a one-bit CRC4 step helper.
package mtm_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    localparam logic FRAME_DATA = 1'b0;
    localparam logic FRAME_CTL  = 1'b1;

    // Positions inside err_flags = {err_data, err_crc, err_op}
    localparam int ERR_DATA = 2;
    localparam int ERR_CRC  = 1;
    localparam int ERR_OP   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TYPE = 2'd1,
        ST_DATA = 2'd2,
        ST_STOP = 2'd3
    } des_state_t;

    // One MSB-first step of CRC4 with polynomial x^4+x+1.
    function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic d);
        logic fb;
        fb = d ^ c[3];
        return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    endfunction

    function automatic logic op_supported(input logic [2:0] o);
        return (o == OP_AND) || (o == OP_OR) || (o == OP_ADD) || (o == OP_SUB);
    endfunction

endpackage

// File: rtl/mtm_alu_crc4.sv
// mtm_alu_crc4
// Combinational CRC4 (x^4+x+1, init 0, MSB first) over a 68-bit word
// laid out as {B, A, 1'b1, OP}.
//   data : 68-bit message, bit 67 is shifted in first
//   crc  : resulting 4-bit remainder
module mtm_alu_crc4
    import mtm_alu_pkg::*;
(
    input  logic [67:0] data,
    output logic [3:0]  crc
);

    logic [3:0] c;

    always_comb begin
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            c = crc4_step(c, data[i]);
        end
        crc = c;
    end

endmodule

// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer
// Serial input stage of mtm_Alu. Frames of 11 bits
// (start 0, type, d[7:0] MSB first, stop 1) are collected into a packet
// of DATA_FRAMES data bytes (B3..B0, A3..A0) followed by one control byte
// {0, OP[2:0], CRC[3:0]}. A checked packet is handed to the ALU core with
// a one-cycle t_valid; a rejected packet gives a one-cycle err_valid with
// exactly one bit of err_flags set.
//   clk       : system clock, sin sampled every rising edge
//   rst       : synchronous active-low reset
//   sin       : serial input, idles high
//   B, A      : operands, held until the next accepted packet
//   op        : opcode
//   t_valid   : good packet strobe
//   err_valid : rejected packet strobe
//   err_flags : {err_data, err_crc, err_op}, zero outside err_valid
module mtm_alu_deserializer
    import mtm_alu_pkg::*;
#(
    parameter int DATA_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic [31:0] B,
    output logic [31:0] A,
    output logic [2:0]  op,
    output logic        t_valid,
    output logic        err_valid,
    output logic [2:0]  err_flags
);

    localparam logic [3:0] FRAMES_FULL = 4'(DATA_FRAMES);

    des_state_t  state;
    logic        frame_type;
    logic [2:0]  bit_cnt;
    logic [7:0]  byte_q;
    logic [3:0]  frame_cnt;
    logic [63:0] stage;      // data bytes shift in at the bottom: byte 0 ends up in [63:56]
    logic [3:0]  crc_calc;

    // The control byte sits complete in byte_q while the stop bit is sampled.
    mtm_alu_crc4 u_crc (
        .data ({stage, 1'b1, byte_q[6:4]}),
        .crc  (crc_calc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            frame_type <= FRAME_DATA;
            bit_cnt    <= 3'd0;
            byte_q     <= 8'h00;
            frame_cnt  <= 4'd0;
            stage      <= 64'h0;
            B          <= 32'h0;
            A          <= 32'h0;
            op         <= 3'b000;
            t_valid    <= 1'b0;
            err_valid  <= 1'b0;
            err_flags  <= 3'b000;
        end else begin
            t_valid   <= 1'b0;
            err_valid <= 1'b0;
            err_flags <= 3'b000;

            case (state)
                ST_IDLE: begin
                    if (!sin) state <= ST_TYPE;
                end

                ST_TYPE: begin
                    frame_type <= sin;
                    bit_cnt    <= 3'd0;
                    state      <= ST_DATA;
                end

                ST_DATA: begin
                    byte_q  <= {byte_q[6:0], sin};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= ST_STOP;
                end

                ST_STOP: begin
                    state <= ST_IDLE;
                    if (!sin) begin
                        // Broken framing: nothing else about this frame is trusted.
                        frame_cnt           <= 4'd0;
                        err_valid           <= 1'b1;
                        err_flags[ERR_DATA] <= 1'b1;
                    end else if (frame_type == FRAME_DATA) begin
                        if (frame_cnt < FRAMES_FULL) begin
                            stage     <= {stage[55:0], byte_q};
                            frame_cnt <= frame_cnt + 4'd1;
                        end else begin
                            frame_cnt           <= 4'd0;
                            err_valid           <= 1'b1;
                            err_flags[ERR_DATA] <= 1'b1;
                        end
                    end else begin
                        frame_cnt <= 4'd0;
                        err_valid <= 1'b1;
                        if (frame_cnt != FRAMES_FULL) begin
                            err_flags[ERR_DATA] <= 1'b1;
                        end else if (crc_calc != byte_q[3:0]) begin
                            err_flags[ERR_CRC] <= 1'b1;
                        end else if (!op_supported(byte_q[6:4])) begin
                            err_flags[ERR_OP] <= 1'b1;
                        end else begin
                            // Good packet overrides the error strobe set above.
                            err_valid <= 1'b0;
                            t_valid   <= 1'b1;
                            B         <= stage[63:32];
                            A         <= stage[31:0];
                            op        <= byte_q[6:4];
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb_mtm_alu_deserializer
// Directed bench for mtm_alu_deserializer. Serial bits are driven right
// after each rising edge and outputs are sampled 1 time unit after the edge
// on which the DUT consumed the last relevant bit. The reference CRC is a
// polynomial long division, independent of the LFSR form in the design.
module tb_mtm_alu_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sin;
    logic [31:0] B;
    logic [31:0] A;
    logic [2:0]  op;
    logic        t_valid;
    logic        err_valid;
    logic [2:0]  err_flags;

    int checks   = 0;
    int failures = 0;
    int tv_cnt   = 0;
    int ev_cnt   = 0;
    int tv0, ev0;

    mtm_alu_deserializer #(.DATA_FRAMES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .B         (B),
        .A         (A),
        .op        (op),
        .t_valid   (t_valid),
        .err_valid (err_valid),
        .err_flags (err_flags)
    );

    always #5 clk = ~clk;

    // Count strobe cycles and check the strobes are mutually exclusive.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (t_valid) tv_cnt++;
            if (err_valid) ev_cnt++;
            checks++;
            assert (!(t_valid && err_valid)) else begin
                failures++;
                $error("FAIL strobe_exclusive: t_valid=%0b err_valid=%0b required not both", t_valid, err_valid);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] crc_model(input logic [31:0] b, input logic [31:0] a, input logic [2:0] o);
        logic [71:0] m;
        m = {b, a, 1'b1, o, 4'b0000};
        for (int i = 71; i >= 4; i--) begin
            if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
        end
        return m[3:0];
    endfunction

    task automatic send_bit(input logic b);
        sin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic t, input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        send_bit(t);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic send_data(input logic [31:0] b, input logic [31:0] a, input int first, input int n);
        logic [63:0] w;
        w = {b, a};
        for (int i = first; i < first + n; i++) send_frame(1'b0, w[63 - 8*i -: 8], 1'b1);
    endtask

    task automatic send_ctl(input logic [2:0] o, input logic [3:0] c);
        send_frame(1'b1, {1'b0, o, c}, 1'b1);
    endtask

    initial begin
        rst = 1'b0;
        sin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_B", 64'(B), 64'h0);
        check("reset_A", 64'(A), 64'h0);
        check("reset_op", 64'(op), 64'h0);
        check("reset_t_valid", 64'(t_valid), 64'h0);
        check("reset_err_valid", 64'(err_valid), 64'h0);
        check("reset_err_flags", 64'(err_flags), 64'h0);
        rst = 1'b1;
        send_bit(1'b1);

        // 1: good ADD packet, CRC hand-computed as 4'hA
        tv0 = tv_cnt; ev0 = ev_cnt;
        send_data(32'h0000_0001, 32'h0000_0002, 0, 8);
        send_ctl(3'b100, 4'hA);
        check("s1_t_valid", 64'(t_valid), 64'h1);
        check("s1_B", 64'(B), 64'h0000_0001);
        check("s1_A", 64'(A), 64'h0000_0002);
        check("s1_op", 64'(op), 64'h4);
        check("s1_err_valid", 64'(err_valid), 64'h0);
        send_bit(1'b1);
        check("s1_t_valid_drop", 64'(t_valid), 64'h0);
        check("s1_tv_pulses", 64'(tv_cnt - tv0), 64'h1);
        check("s1_ev_pulses", 64'(ev_cnt - ev0), 64'h0);

        // 2: same packet, CRC bit 0 flipped
        tv0 = tv_cnt;
        send_data(32'h0000_0001, 32'h0000_0002, 0, 8);
        send_ctl(3'b100, 4'hB);
        check("s2_err_valid", 64'(err_valid), 64'h1);
        check("s2_err_flags", 64'(err_flags), 64'h2);
        check("s2_t_valid", 64'(t_valid), 64'h0);
        send_bit(1'b1);
        check("s2_err_valid_drop", 64'(err_valid), 64'h0);
        check("s2_err_flags_drop", 64'(err_flags), 64'h0);
        check("s2_B_held", 64'(B), 64'h0000_0001);
        check("s2_A_held", 64'(A), 64'h0000_0002);
        check("s2_op_held", 64'(op), 64'h4);
        check("s2_tv_pulses", 64'(tv_cnt - tv0), 64'h0);

        // 3: short packet (7 data frames), then a good AND packet back-to-back
        send_data(32'h1111_1111, 32'h2222_2222, 0, 7);
        send_ctl(3'b000, crc_model(32'h1111_1111, 32'h2222_2222, 3'b000));
        check("s3_err_valid", 64'(err_valid), 64'h1);
        check("s3_err_flags", 64'(err_flags), 64'h4);
        send_data(32'hFFFF_0000, 32'h0F0F_0F0F, 0, 8);
        send_ctl(3'b000, crc_model(32'hFFFF_0000, 32'h0F0F_0F0F, 3'b000));
        check("s3_t_valid", 64'(t_valid), 64'h1);
        check("s3_B", 64'(B), 64'hFFFF_0000);
        check("s3_A", 64'(A), 64'h0F0F_0F0F);
        check("s3_op", 64'(op), 64'h0);
        send_bit(1'b1);

        // 4: unsupported opcode with matching CRC, then SUB
        send_data(32'hCAFE_0001, 32'h0000_0007, 0, 8);
        send_ctl(3'b011, crc_model(32'hCAFE_0001, 32'h0000_0007, 3'b011));
        check("s4_err_valid", 64'(err_valid), 64'h1);
        check("s4_err_flags", 64'(err_flags), 64'h1);
        check("s4_B_held", 64'(B), 64'hFFFF_0000);
        send_data(32'h0000_0010, 32'h0000_0003, 0, 8);
        send_ctl(3'b101, crc_model(32'h0000_0010, 32'h0000_0003, 3'b101));
        check("s4_t_valid", 64'(t_valid), 64'h1);
        check("s4_op", 64'(op), 64'h5);
        check("s4_B", 64'(B), 64'h0000_0010);
        check("s4_A", 64'(A), 64'h0000_0003);
        send_bit(1'b1);

        // 5: stop bit 0 on data frame index 3; rest of the packet then gives err_data on control
        ev0 = ev_cnt; tv0 = tv_cnt;
        send_data(32'h0102_0304, 32'h0506_0708, 0, 3);
        send_frame(1'b0, 8'h04, 1'b0);
        check("s5_stop_err_valid", 64'(err_valid), 64'h1);
        check("s5_stop_err_flags", 64'(err_flags), 64'h4);
        send_data(32'h0102_0304, 32'h0506_0708, 4, 4);
        send_ctl(3'b100, crc_model(32'h0102_0304, 32'h0506_0708, 3'b100));
        check("s5_ctl_err_valid", 64'(err_valid), 64'h1);
        check("s5_ctl_err_flags", 64'(err_flags), 64'h4);
        send_bit(1'b1);
        check("s5_ev_pulses", 64'(ev_cnt - ev0), 64'h2);
        check("s5_tv_pulses", 64'(tv_cnt - tv0), 64'h0);
        send_data(32'hDEAD_BEEF, 32'h0000_0055, 0, 8);
        send_ctl(3'b100, crc_model(32'hDEAD_BEEF, 32'h0000_0055, 3'b100));
        check("s5_t_valid", 64'(t_valid), 64'h1);
        check("s5_B", 64'(B), 64'hDEAD_BEEF);
        check("s5_A", 64'(A), 64'h0000_0055);
        send_bit(1'b1);

        // 6: reset inside frame 5, then a fresh OR packet
        send_data(32'h1234_5678, 32'h9ABC_DEF0, 0, 5);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b0;
        send_bit(1'b1);
        check("s6_rst_B", 64'(B), 64'h0);
        check("s6_rst_A", 64'(A), 64'h0);
        check("s6_rst_op", 64'(op), 64'h0);
        check("s6_rst_t_valid", 64'(t_valid), 64'h0);
        check("s6_rst_err_valid", 64'(err_valid), 64'h0);
        check("s6_rst_err_flags", 64'(err_flags), 64'h0);
        rst = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        ev0 = ev_cnt;
        send_data(32'h1234_5678, 32'h9ABC_DEF0, 0, 8);
        send_ctl(3'b001, crc_model(32'h1234_5678, 32'h9ABC_DEF0, 3'b001));
        check("s6_t_valid", 64'(t_valid), 64'h1);
        check("s6_B", 64'(B), 64'h1234_5678);
        check("s6_A", 64'(A), 64'h9ABC_DEF0);
        check("s6_op", 64'(op), 64'h1);
        send_bit(1'b1);
        check("s6_t_valid_drop", 64'(t_valid), 64'h0);
        check("s6_ev_pulses", 64'(ev_cnt - ev0), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
